elastic_reg_pipe: RTL and testbench

//  Parametrised multi-stage register pipeline with a valid/ready handshake on both sides.

---
 rtl/elastic_reg_pipe.sv | 115 +++++++++++
 tb/tb_elastic_reg_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_reg_pipe.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit data with valid/ready on
// both sides, synchronous flush and a registered occupancy count.
module elastic_reg_pipe #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int unsigned      OCC_W   = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

  logic [DEPTH-1:0]            vld_vec;
  logic [DEPTH-1:0][WIDTH-1:0] dat_vec;
  logic [DEPTH:0]              rdy;
  logic                        in_xfer;
  logic                        out_xfer;
  logic [OCC_W-1:0]            occ_q;
  logic [OCC_W-1:0]            occ_d;

  // A stage is ready when it is empty or its downstream neighbour is ready.
  assign rdy[DEPTH] = out_ready;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             vld_q;
    logic             vld_d;
    logic [WIDTH-1:0] dat_q;
    logic [WIDTH-1:0] dat_d;
    logic             up_vld;
    logic [WIDTH-1:0] up_dat;

    if (gi == 0) begin : g_head
      assign up_vld = in_valid & ~flush;
      assign up_dat = in_data;
    end else begin : g_body
      assign up_vld = vld_vec[gi-1];
      assign up_dat = dat_vec[gi-1];
    end

    assign rdy[gi]     = ~vld_q | rdy[gi+1];
    assign vld_vec[gi] = vld_q;
    assign dat_vec[gi] = dat_q;

    // Data only moves with a valid word so a bubble never clobbers held data.
    always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (flush) begin
        vld_d = 1'b0;
      end else if (rdy[gi]) begin
        vld_d = up_vld;
      end
      if (rdy[gi] && up_vld) begin
        dat_d = up_dat;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        dat_q <= RESET_VAL;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = vld_vec[DEPTH-1] & ~flush;
  assign out_data  = dat_vec[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!in_xfer && out_xfer) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

  a_occ_matches_vld: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy == OCC_W'($countones(vld_vec)));

  a_occ_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= OCC_MAX);

  // A presented word must not change or vanish until it is taken (or flushed).
  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (flush || (out_valid && $stable(out_data))));

endmodule

// File: tb/tb_elastic_reg_pipe.sv
// Scoreboard bench for elastic_reg_pipe: runs the directed suite on an 8-bit,
// 4-stage instance and then on a 32-bit, 1-stage instance.
module tb_elastic_reg_pipe;
  logic clk;
  logic rst_n;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [7:0] a_in_data, a_out_data;
  logic [2:0] a_occ;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [31:0] b_in_data, b_out_data;
  logic [0:0]  b_occ;

  elastic_reg_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .flush(a_flush), .occupancy(a_occ)
  );

  elastic_reg_pipe #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'hDEAD_BEEF)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .flush(b_flush), .occupancy(b_occ)
  );

  typedef struct {
    logic [31:0] d;
    int          c;
  } item_t;

  item_t sbq[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    act = 0;
  bit    chk_lat = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic g_ir();  return (act == 1) ? b_in_ready  : a_in_ready;  endfunction
  function automatic logic g_iv();  return (act == 1) ? b_in_valid  : a_in_valid;  endfunction
  function automatic logic g_ov();  return (act == 1) ? b_out_valid : a_out_valid; endfunction
  function automatic logic g_or();  return (act == 1) ? b_out_ready : a_out_ready; endfunction
  function automatic logic g_fl();  return (act == 1) ? b_flush     : a_flush;     endfunction
  function automatic logic [31:0] g_id();  return (act == 1) ? b_in_data  : {24'h0, a_in_data};  endfunction
  function automatic logic [31:0] g_od();  return (act == 1) ? b_out_data : {24'h0, a_out_data}; endfunction
  function automatic logic [31:0] g_occ(); return (act == 1) ? {31'h0, b_occ} : {29'h0, a_occ}; endfunction
  function automatic int dep(); return (act == 1) ? 1 : 4; endfunction
  function automatic logic [31:0] rv(); return (act == 1) ? 32'hDEAD_BEEF : 32'h0000_005A; endfunction
  function automatic logic [31:0] wd(logic [31:0] d);
    return (act == 1) ? (32'hC0DE_0000 | d) : d;
  endfunction

  task automatic set_in(logic v, logic [31:0] d);
    if (act == 1) begin b_in_valid = v; b_in_data = d; end
    else begin a_in_valid = v; a_in_data = d[7:0]; end
  endtask

  task automatic set_or(logic v);
    if (act == 1) b_out_ready = v; else a_out_ready = v;
  endtask

  task automatic set_fl(logic v);
    if (act == 1) b_flush = v; else a_flush = v;
  endtask

  task automatic check(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut=%0d t=%0t: got=%0h want=%0h", nm, act, $time, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid with d until the pipe takes it; waited = cycles stalled.
  task automatic send(logic [31:0] d, output int waited);
    set_in(1'b1, wd(d));
    waited = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (g_ir()) begin
        tick();
        return;
      end
      waited++;
      tick();
    end
    total++;
    bad++;
    $display("FAIL send_timeout dut=%0d: got=no accept want=accept of %0h", act, d);
  endtask

  task automatic mon_step();
    item_t it;
    check("occ_vs_scoreboard", g_occ(), 32'(sbq.size()));
    if (g_fl()) begin
      sbq.delete();
      return;
    end
    if (g_ov() && g_or()) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected dut=%0d t=%0t: got=%0h want=no word", act, $time, g_od());
      end else begin
        it = sbq.pop_front();
        check("out_order", g_od(), it.d);
        if (chk_lat) check("latency", 32'(cyc - it.c), 32'(dep()));
        $display("txn dut=%0d out=%0h cyc=%0d", act, g_od(), cyc);
      end
    end
    if (g_iv() && g_ir()) begin
      it.d = g_id();
      it.c = cyc;
      sbq.push_back(it);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) sbq.delete();
    else mon_step();
  end

  task automatic run_suite();
    int w;
    int n;

    // Reset held for three cycles with in_valid asserted.
    rst_n = 1'b0;
    set_or(1'b0);
    set_fl(1'b0);
    set_in(1'b1, wd(32'h3C));
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", g_ov(), 0);
      check("rst_in_ready", g_ir(), 1);
      check("rst_occ", g_occ(), 0);
      check("rst_out_data", g_od(), rv());
      tick();
    end
    set_in(1'b0, 0);
    rst_n = 1'b1;
    tick();

    // Back-to-back stream with fixed latency.
    set_or(1'b1);
    chk_lat = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      send(32'(i), w);
      check("stream_no_stall", w, 0);
    end
    set_in(1'b0, 0);
    repeat (dep() + 2) tick();
    chk_lat = 1'b0;
    check("stream_drained", 32'(sbq.size()), 0);

    // Backpressure until full, then release.
    set_or(1'b0);
    for (int i = 0; i < dep(); i++) begin
      send(32'hA0 + 32'(i), w);
      check("bp_fill_ready", w, 0);
    end
    set_in(1'b1, wd(32'hA0 + 32'(dep())));
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", g_ir(), 0);
      check("bp_occ", g_occ(), 32'(dep()));
      check("bp_out_valid", g_ov(), 1);
      check("bp_out_data", g_od(), wd(32'hA0));
      tick();
    end
    set_or(1'b1);
    send(32'hA0 + 32'(dep()), w);
    check("bp_release_ready", w, 0);
    set_in(1'b0, 0);
    repeat (dep() + 2) tick();
    check("bp_drained", 32'(sbq.size()), 0);

    // Full pipe with simultaneous in/out.
    set_or(1'b0);
    for (int i = 0; i < dep(); i++) send(32'h40 + 32'(i), w);
    set_or(1'b1);
    for (int i = 0; i < 4; i++) begin
      send(32'h77 + 32'(i), w);
      check("full_in_ready", w, 0);
      check("full_occ", g_occ(), 32'(dep()));
    end
    set_in(1'b0, 0);
    repeat (dep() + 2) tick();
    check("full_drained", 32'(sbq.size()), 0);

    // Flush with a partly filled pipe.
    n = (dep() < 3) ? dep() : 3;
    set_or(1'b0);
    for (int i = 0; i < n; i++) send(32'h90 + 32'(i), w);
    check("fl_pre_occ", g_occ(), 32'(n));
    set_fl(1'b1);
    set_in(1'b1, wd(32'hEE));
    @(negedge clk);
    check("fl_out_valid", g_ov(), 0);
    check("fl_in_ready", g_ir(), 0);
    tick();
    set_fl(1'b0);
    set_in(1'b0, 0);
    check("fl_occ", g_occ(), 0);
    check("fl_out_valid_after", g_ov(), 0);
    set_or(1'b1);
    chk_lat = 1'b1;
    send(32'h55, w);
    check("fl_next_ready", w, 0);
    set_in(1'b0, 0);
    repeat (dep() + 2) tick();
    chk_lat = 1'b0;
    check("fl_drained", 32'(sbq.size()), 0);

    // Asynchronous reset between edges with words in flight.
    n = (dep() < 2) ? dep() : 2;
    set_or(1'b0);
    for (int i = 0; i < n; i++) send(32'h31 + 32'(i), w);
    set_in(1'b0, 0);
    check("arst_pre_occ", g_occ(), 32'(n));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", g_ov(), 0);
    check("arst_occ", g_occ(), 0);
    check("arst_out_data", g_od(), rv());
    check("arst_in_ready", g_ir(), 1);
    tick();
    tick();
    set_or(1'b1);
    rst_n = 1'b1;
    repeat (dep() + 2) begin
      @(negedge clk);
      check("arst_no_emit", g_ov(), 0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_flush = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_flush = 1'b0;
    tick();
    act = 0;
    run_suite();
    rst_n = 1'b0;
    act = 1;
    run_suite();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=still running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
